// File: rtl/npu_rd_pkg.sv
// npu_rd_pkg: shared FSM type and packing constants for the NPU result reader.
package npu_rd_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
    localparam logic MODE_BANKED = 1'b0;
    localparam logic MODE_LINEAR = 1'b1;
    localparam int BYTE_W = 8;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/npu_rd_skid_fifo.sv
// npu_rd_skid_fifo: 2-entry output skid buffer; push and pop may coincide even when full.
module npu_rd_skid_fifo
    import npu_rd_pkg::*;
#(
    parameter int W = WORD_BYTES * BYTE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_pop  = pop_i && count_q != 2'd0;
    assign do_push = push_i && (count_q != 2'd2 || do_pop);
    assign count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_q ^ do_push;
            rd_ptr_q <= rd_ptr_q ^ do_pop;
            count_q  <= count_d;
        end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = count_q != 2'd0;
    assign count_o = count_q;
endmodule

// File: rtl/npu_result_reader.sv
// npu_result_reader: fetches a range of the 4-bank result RAM and streams packed 32-bit words.
// Optional running checksum of accepted words when NPU_RDR_CHECKSUM_EN is defined.
module npu_result_reader
    import npu_rd_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data0,
    input  logic [7:0]        rd_data1,
    input  logic [7:0]        rd_data2,
    input  logic [7:0]        rd_data3,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       checksum
);
    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  issue_left_q, issue_left_d;
    logic [LEN_W-1:0]  acc_left_q, acc_left_d;
    logic [1:0]        byte_q, byte_d;
    logic [1:0]        inflight_q, inflight_d;
    logic              rv_q, rv_last_q;
    logic [23:0]       pack_q, pack_d;
    logic              zero_done_q, zero_done_d;
    logic              start_ok, pop, push, last_acc, word_first, word_end;
    logic [1:0]        fifo_cnt;
    logic [2:0]        credit;
    logic [31:0]       push_data;

    assign start_ok   = start && state_q == IDLE && !zero_done_q;
    assign pop        = out_valid && out_ready;
    assign last_acc   = pop && acc_left_q == LEN_W'(1);
    assign word_first = mode_q == MODE_BANKED || byte_q == 2'd0;
    assign word_end   = mode_q == MODE_BANKED || byte_q == 2'd3;
    // Credit is reserved per word on its first read, so linear bytes 1..3 never stall.
    assign credit     = {1'b0, fifo_cnt} + {1'b0, inflight_q} - {2'b00, pop};
    assign push       = rv_q && rv_last_q;
    assign inflight_d = inflight_q + {1'b0, rd_en && word_first} - {1'b0, push};
    assign pack_d     = rv_q ? {rd_data0, pack_q[23:8]} : pack_q;
    assign push_data  = mode_q == MODE_LINEAR ? {rd_data0, pack_q}
                                              : {rd_data0, rd_data1, rd_data2, rd_data3};

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        acc_left_d   = acc_left_q;
        byte_d       = byte_q;
        zero_done_d  = start_ok && word_count == '0;
        rd_en        = state_q == FETCH && (!word_first || credit < 3'd2);
        if (start_ok) begin
            mode_d       = mode;
            addr_d       = base_addr;
            issue_left_d = word_count;
            acc_left_d   = word_count;
            byte_d       = 2'd0;
            state_d      = word_count == '0 ? IDLE : FETCH;
        end
        if (rd_en) begin
            addr_d = addr_q + ADDR_W'(1);
            byte_d = mode_q == MODE_LINEAR ? byte_q + 2'd1 : 2'd0;
        end
        if (rd_en && word_end) begin
            issue_left_d = issue_left_q - LEN_W'(1);
            state_d      = issue_left_q == LEN_W'(1) ? DRAIN : state_d;
        end
        if (pop) acc_left_d = acc_left_q - LEN_W'(1);
        if (last_acc) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= MODE_BANKED;
            addr_q       <= '0;
            issue_left_q <= '0;
            acc_left_q   <= '0;
            byte_q       <= 2'd0;
            inflight_q   <= 2'd0;
            rv_q         <= 1'b0;
            rv_last_q    <= 1'b0;
            pack_q       <= '0;
            zero_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            acc_left_q   <= acc_left_d;
            byte_q       <= byte_d;
            inflight_q   <= inflight_d;
            rv_q         <= rd_en;
            rv_last_q    <= word_end;
            pack_q       <= pack_d;
            zero_done_q  <= zero_done_d;
        end

    npu_rd_skid_fifo u_fifo (
        .clk    (clk),
        .rst    (reset),
        .push_i (push),
        .data_i (push_data),
        .pop_i  (pop),
        .data_o (out_data),
        .valid_o(out_valid),
        .count_o(fifo_cnt)
    );

    assign rd_addr = addr_q;
    assign done    = zero_done_q || last_acc;
    assign busy    = state_q != IDLE || zero_done_q;

`ifdef NPU_RDR_CHECKSUM_EN
    logic [31:0] sum_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) sum_q <= '0;
        else if (start_ok) sum_q <= '0;
        else if (pop) sum_q <= sum_q + out_data;
    // Includes the word accepted this cycle so the value is complete when done pulses.
    assign checksum = sum_q + (pop ? out_data : 32'd0);
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_npu_result_reader.sv
// tb_npu_result_reader: scoreboard bench for npu_result_reader with a registered 4-bank RAM model.
module tb_npu_result_reader;
    logic        clk = 0, reset = 0, start = 0, mode = 0, out_ready = 0;
    logic [11:0] base_addr = 0, word_count = 0;
    logic        busy, done, rd_en, out_valid;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data0 = 0, rd_data1 = 0, rd_data2 = 0, rd_data3 = 0;
    logic [31:0] out_data, checksum;
    logic [7:0]  m0 [4096], m1 [4096], m2 [4096], m3 [4096];
    logic [31:0] exp_q [$];
    logic [31:0] sum_exp;
    logic        pop;
    int          total = 0, bad = 0, cyc = 0, issued = 0, accepted = 0;

    npu_result_reader dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rd_en) begin
            rd_data0 <= m0[rd_addr];
            rd_data1 <= m1[rd_addr];
            rd_data2 <= m2[rd_addr];
            rd_data3 <= m3[rd_addr];
        end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    function automatic logic [31:0] model_word(input logic m, input logic [11:0] a);
        logic [11:0] a1, a2, a3;
        a1 = a + 12'd1;
        a2 = a + 12'd2;
        a3 = a + 12'd3;
        return m ? {m0[a3], m0[a2], m0[a1], m0[a]} : {m0[a], m1[a], m2[a], m3[a]};
    endfunction

    function automatic logic [32:0] take();
        if (exp_q.size() == 0) return 33'h0;
        return {1'b1, exp_q.pop_front()};
    endfunction

    task automatic step(input logic rdy, input logic st);
        @(negedge clk);
        out_ready = rdy;
        start = st;
        #1;
        cyc++;
        pop = out_valid && out_ready;
        issued += int'(rd_en);
        accepted += int'(pop);
    endtask

    task automatic launch(input logic m, input logic [11:0] b, input logic [11:0] n, input logic rdy);
        logic [11:0] a;
        mode = m;
        base_addr = b;
        word_count = n;
        sum_exp = 0;
        for (int w = 0; w < int'(n); w++) begin
            a = m ? b + 12'(4 * w) : b + 12'(w);
            exp_q.push_back(model_word(m, a));
            sum_exp += model_word(m, a);
        end
        issued = 0;
        accepted = 0;
        step(rdy, 1'b1);
        cyc = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        #2 reset = 1;
        #2;
        total++;
        if ({busy, done, rd_en, out_valid} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, rd_en, out_valid});
        end
        total++;
        if (rd_addr !== 12'h0) begin bad++; $display("FAIL reset_addr got=%h want=000", rd_addr); end
        total++;
        if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        total++;
        if (checksum !== 32'h0) begin bad++; $display("FAIL reset_checksum got=%h want=0", checksum); end
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_banked;
        int first_rd = -1, first_v = -1, got = 0, ndone = 0;
        logic [32:0] e;
        launch(1'b0, 12'd0, 12'd4, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            if (rd_en && first_rd < 0) first_rd = cyc;
            if (out_valid && first_v < 0) first_v = cyc;
            if (pop) begin
                e = take();
                got++;
                total++;
                if ({1'b1, out_data} !== e) begin bad++; $display("FAIL banked_word got=%h want=%h", out_data, e); end
                total++;
                if (cyc != 2 + got) begin bad++; $display("FAIL banked_rate got=cycle%0d want=cycle%0d", cyc, 2 + got); end
            end
            if (done) begin
                ndone++;
                total++;
                if (!(pop && got == 4)) begin bad++; $display("FAIL banked_done_align got=%0d words want=4", got); end
            end
        end
        total++;
        if (first_rd != 1) begin bad++; $display("FAIL banked_rd_latency got=%0d want=1", first_rd); end
        total++;
        if (first_v != 3) begin bad++; $display("FAIL banked_valid_latency got=%0d want=3", first_v); end
        total++;
        if (ndone != 1 || got != 4) begin bad++; $display("FAIL banked_count got=%0d/%0d want=4/1", got, ndone); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL banked_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_linear;
        int got = 0, ndone = 0;
        logic [32:0] e;
        for (int i = 0; i < 8; i++) m0[1856 + i] = 8'h10 + 8'(i);
        launch(1'b1, 12'd1856, 12'd2, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            if (cyc >= 1 && cyc <= 4) begin
                total++;
                if (!rd_en || rd_addr !== 12'(1855 + cyc)) begin
                    bad++; $display("FAIL linear_rd got=%b/%h want=1/%h", rd_en, rd_addr, 12'(1855 + cyc));
                end
            end
            if (pop) begin
                e = take();
                got++;
                total++;
                if ({1'b1, out_data} !== e) begin bad++; $display("FAIL linear_word got=%h want=%h", out_data, e); end
                total++;
                if (cyc != 2 + 4 * got) begin bad++; $display("FAIL linear_timing got=cycle%0d want=cycle%0d", cyc, 2 + 4 * got); end
            end
            if (done) ndone++;
        end
        total++;
        if (got != 2 || ndone != 1 || issued != 8) begin
            bad++; $display("FAIL linear_count got=%0d/%0d/%0d want=2/1/8", got, ndone, issued);
        end
    endtask

    task automatic test_backpressure;
        int got = 0, ndone = 0;
        logic prev_stall = 0;
        logic [31:0] prev_data = 0;
        logic [32:0] e;
        logic rdy;
        launch(1'b0, 12'd16, 12'd8, 1'b0);
        for (int i = 0; i < 40; i++) begin
            rdy = i < 8 ? (i % 2 == 0) : i >= 13;
            step(rdy, 1'b0);
            total++;
            if (issued - accepted > 2) begin bad++; $display("FAIL bp_outstanding got=%0d want<=2", issued - accepted); end
            if (prev_stall) begin
                total++;
                if (!out_valid || out_data !== prev_data) begin
                    bad++; $display("FAIL bp_hold got=%b/%h want=1/%h", out_valid, out_data, prev_data);
                end
            end
            if (pop) begin
                e = take();
                got++;
                total++;
                if ({1'b1, out_data} !== e) begin bad++; $display("FAIL bp_word got=%h want=%h", out_data, e); end
            end
            if (done) ndone++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
        total++;
        if (got != 8 || ndone != 1 || exp_q.size() != 0) begin
            bad++; $display("FAIL bp_count got=%0d/%0d want=8/1", got, ndone);
        end
    endtask

    task automatic test_edge;
        int got = 0, ndone = 0, first_done = -1, nvalid = 0;
        logic [11:0] wa = 12'hFFF;
        logic [32:0] e;
        launch(1'b0, 12'd5, 12'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            if (done) begin ndone++; if (first_done < 0) first_done = cyc; end
            nvalid += int'(out_valid);
        end
        total++;
        if (first_done != 1 || ndone != 1) begin bad++; $display("FAIL zero_done got=%0d/%0d want=1/1", first_done, ndone); end
        total++;
        if (issued != 0 || nvalid != 0) begin bad++; $display("FAIL zero_reads got=%0d/%0d want=0/0", issued, nvalid); end
        launch(1'b0, 12'hFFF, 12'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (rd_en) begin
                total++;
                if (rd_addr !== wa) begin bad++; $display("FAIL wrap_addr got=%h want=%h", rd_addr, wa); end
                wa = wa + 12'd1;
            end
            if (pop) begin
                e = take();
                got++;
                total++;
                if ({1'b1, out_data} !== e) begin bad++; $display("FAIL wrap_word got=%h want=%h", out_data, e); end
            end
        end
        total++;
        if (got != 2 || issued != 2) begin bad++; $display("FAIL wrap_count got=%0d/%0d want=2/2", got, issued); end
        got = 0;
        ndone = 0;
        launch(1'b0, 12'd32, 12'd6, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            if (i == 2) begin mode = 1'b1; base_addr = 12'd100; word_count = 12'd3; end
            step(1'b1, i == 2 || i == 8);
            if (pop) begin
                e = take();
                got++;
                total++;
                if ({1'b1, out_data} !== e) begin bad++; $display("FAIL midstart_word got=%h want=%h", out_data, e); end
            end
            if (done) begin
                ndone++;
                total++;
                if (cyc != 8) begin bad++; $display("FAIL midstart_done got=cycle%0d want=cycle8", cyc); end
            end
        end
        total++;
        if (got != 6 || ndone != 1 || issued != 6 || busy !== 1'b0) begin
            bad++; $display("FAIL midstart_count got=%0d/%0d/%0d/%b want=6/1/6/0", got, ndone, issued, busy);
        end
    endtask

    task automatic test_reset_mid;
        int got = 0, ndone = 0;
        logic [32:0] e;
        launch(1'b0, 12'd64, 12'd8, 1'b1);
        for (int i = 0; i < 10 && got < 3; i++) begin
            step(1'b1, 1'b0);
            if (pop) begin
                e = take();
                got++;
                total++;
                if ({1'b1, out_data} !== e) begin bad++; $display("FAIL rstmid_word got=%h want=%h", out_data, e); end
            end
        end
        #1 reset = 1;
        #1;
        total++;
        if ({busy, done, rd_en, out_valid} !== 4'b0 || out_data !== 32'h0 || rd_addr !== 12'h0) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%h/%h want=0000/0/0", {busy, done, rd_en, out_valid}, out_data, rd_addr);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 0;
        got = 0;
        launch(1'b0, 12'd200, 12'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            if (pop) begin
                e = take();
                got++;
                total++;
                if ({1'b1, out_data} !== e) begin bad++; $display("FAIL rstmid_fresh got=%h want=%h", out_data, e); end
            end
            if (done) ndone++;
        end
        total++;
        if (got != 1 || ndone != 1) begin bad++; $display("FAIL rstmid_count got=%0d/%0d want=1/1", got, ndone); end
    endtask

    task automatic test_checksum;
        int ndone = 0;
        logic [31:0] want;
        logic [32:0] e;
        launch(1'b0, 12'd0, 12'd4, 1'b1);
`ifdef NPU_RDR_CHECKSUM_EN
        want = sum_exp;
`else
        want = 32'h0;
`endif
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (pop) begin
                e = take();
                total++;
                if ({1'b1, out_data} !== e) begin bad++; $display("FAIL cksum_word got=%h want=%h", out_data, e); end
            end
            if (done) begin
                ndone++;
                total++;
                if (checksum !== want) begin bad++; $display("FAIL checksum got=%h want=%h", checksum, want); end
            end
        end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL cksum_done got=%0d want=1", ndone); end
    endtask

    initial begin
        logic [11:0] av;
        for (int a = 0; a < 4096; a++) begin
            av = 12'(a);
            m0[a] = av[7:0];
            m1[a] = av[7:0] ^ 8'h01;
            m2[a] = av[7:0] ^ 8'h02;
            m3[a] = av[7:0] ^ 8'h03;
        end
        test_reset;
        test_banked;
        test_linear;
        test_backpressure;
        test_edge;
        test_reset_mid;
        test_checksum;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
